// File: rtl/sift_pkg.sv
`default_nettype none
// ============================================================================
// Module     : sift_pkg
// Description: Shared constants for the SIFT gradient front end: image
//              geometry, source BRAM latency, FSM and neighbour encodings.
// Revision   : 1.0 - initial release
// ============================================================================
package sift_pkg;

  localparam int BIT_DEPTH = 8;
  localparam int WIDTH     = 64;
  localparam int HEIGHT    = 64;
  localparam int ADDR_W    = $clog2(WIDTH * HEIGHT);
  // Source BRAM read latency (address to data, registered output)
  localparam int BRAM_LAT  = 2;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Neighbour select, in fetch order
  localparam logic [1:0] NB_L = 2'd0;
  localparam logic [1:0] NB_R = 2'd1;
  localparam logic [1:0] NB_U = 2'd2;
  localparam logic [1:0] NB_D = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gradient_addr_gen.sv
`default_nettype none
// ============================================================================
// Module     : gradient_addr_gen
// Description: Pixel x/y counters, clamped (edge-replicating) neighbour
//              address mux and last-pixel flag. The neighbour address is
//              formed from the *next* pixel coordinates so the caller can
//              register it on the same edge that advances the counters.
// Revision   : 1.0 - initial release
// ============================================================================
module gradient_addr_gen
  import sift_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int AW     = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          clear_in,
  input  logic          advance_in,
  input  logic [1:0]    sel_in,
  output logic [AW-1:0] pix_addr_out,
  output logic [AW-1:0] nb_addr_out,
  output logic          last_out
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q, x_d, nx_w;
  logic [YW-1:0] y_q, y_d, ny_w;

  // Next-pixel coordinates: row-major walk, x fastest
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_in) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_in) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Clamped neighbour coordinate of the next pixel
  always_comb begin
    nx_w = x_d;
    ny_w = y_d;
    case (sel_in)
      NB_L:    nx_w = (x_d == '0)    ? '0    : x_d - 1'b1;
      NB_R:    nx_w = (x_d == X_MAX) ? X_MAX : x_d + 1'b1;
      NB_U:    ny_w = (y_d == '0)    ? '0    : y_d - 1'b1;
      default: ny_w = (y_d == Y_MAX) ? Y_MAX : y_d + 1'b1;
    endcase
  end

  assign nb_addr_out  = AW'(int'(ny_w) * WIDTH + int'(nx_w));
  assign pix_addr_out = AW'(int'(y_q) * WIDTH + int'(x_q));
  assign last_out     = (x_q == X_MAX) && (y_q == Y_MAX);

  // Coordinate counters
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sift_gradient_image.sv
`default_nettype none
// ============================================================================
// Module     : sift_gradient_image
// Description: Walks a WIDTH x HEIGHT image in an external BRAM, computes
//              central-difference X/Y gradients per pixel and writes them to
//              two downstream BRAM write ports. 7 cycles per pixel:
//              4 fetch, 2 wait, 1 write.
// Revision   : 1.0 - initial release
// ============================================================================
module sift_gradient_image
#(
  parameter int BIT_DEPTH = sift_pkg::BIT_DEPTH,
  parameter int WIDTH     = sift_pkg::WIDTH,
  parameter int HEIGHT    = sift_pkg::HEIGHT,
  parameter int AW        = $clog2(WIDTH * HEIGHT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  output logic [AW-1:0]        ext_read_addr,
  output logic                 ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0] ext_pixel_in,
  output logic [AW-1:0]        x_write_addr,
  output logic                 x_write_valid,
  output logic [BIT_DEPTH-1:0] x_pixel_out,
  output logic [AW-1:0]        y_write_addr,
  output logic                 y_write_valid,
  output logic [BIT_DEPTH-1:0] y_pixel_out,
  input  logic                 start_in,
  output logic                 gradient_done
);

  import sift_pkg::*;

  // Phase within a pixel (0..6); data for the address issued in phase p
  // arrives in phase p+BRAM_LAT.
  localparam logic [2:0] PH_FETCH_LAST = 3'd3;
  localparam logic [2:0] PH_CAP_L      = 3'(BRAM_LAT + 0);
  localparam logic [2:0] PH_CAP_R      = 3'(BRAM_LAT + 1);
  localparam logic [2:0] PH_CAP_U      = 3'(BRAM_LAT + 2);
  localparam logic [2:0] PH_CAP_D      = 3'(BRAM_LAT + 3);

  logic [2:0]           state_q, state_d;
  logic [2:0]           ph_q, ph_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [BIT_DEPTH-1:0] l_q, l_d, r_q, r_d, u_q, u_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [BIT_DEPTH-1:0] gx_q, gx_d, gy_q, gy_d;
  logic                 done_q, done_d;

  logic                 clear_w, advance_w, last_w, active_w;
  logic [1:0]           sel_w;
  logic [AW-1:0]        pix_addr_w, nb_addr_w;
  logic signed [BIT_DEPTH:0] dx_w, dy_w;

  gradient_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .AW     (AW)
  ) u_addr_gen (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clear_in     (clear_w),
    .advance_in   (advance_w),
    .sel_in       (sel_w),
    .pix_addr_out (pix_addr_w),
    .nb_addr_out  (nb_addr_w),
    .last_out     (last_w)
  );

  // Counter control and which neighbour address to load next
  always_comb begin
    clear_w   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_in;
    advance_w = (state_q == ST_WRITE) && !last_w;
    sel_w     = NB_L;
    if ((state_q == ST_FETCH) && (ph_q != PH_FETCH_LAST)) begin
      sel_w = ph_q[1:0] + 2'd1;
    end
  end

  assign active_w = (state_q == ST_FETCH) || (state_q == ST_WAIT);

  // Arithmetic shift floors, so L=255,R=0 gives -128 and L=0,R=255 gives 127.
  // D is taken straight from the BRAM in its arrival cycle so the write
  // registers are ready on the WRITE cycle itself.
  assign dx_w = $signed({1'b0, r_q}) - $signed({1'b0, l_q});
  assign dy_w = $signed({1'b0, ext_pixel_in}) - $signed({1'b0, u_q});

  // FSM, neighbour capture and output register loading
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = rd_valid_q;
    l_d        = l_q;
    r_d        = r_q;
    u_d        = u_q;
    wr_addr_d  = wr_addr_q;
    wr_valid_d = 1'b0;
    gx_d       = gx_q;
    gy_d       = gy_q;
    done_d     = done_q;

    if (active_w) begin
      if (ph_q == PH_CAP_L) l_d = ext_pixel_in;
      if (ph_q == PH_CAP_R) r_d = ext_pixel_in;
      if (ph_q == PH_CAP_U) u_d = ext_pixel_in;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          state_d    = ST_FETCH;
          ph_d       = 3'd0;
          rd_addr_d  = nb_addr_w;
          rd_valid_d = 1'b1;
          done_d     = 1'b0;
        end
      end
      ST_FETCH: begin
        ph_d = ph_q + 3'd1;
        if (ph_q == PH_FETCH_LAST) begin
          state_d = ST_WAIT;
        end else begin
          rd_addr_d = nb_addr_w;
        end
      end
      ST_WAIT: begin
        ph_d = ph_q + 3'd1;
        if (ph_q == PH_CAP_D) begin
          state_d    = ST_WRITE;
          wr_addr_d  = pix_addr_w;
          wr_valid_d = 1'b1;
          gx_d       = BIT_DEPTH'(dx_w >>> 1);
          gy_d       = BIT_DEPTH'(dy_w >>> 1);
        end
      end
      ST_WRITE: begin
        ph_d = 3'd0;
        if (last_w) begin
          state_d    = ST_DONE;
          rd_valid_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          state_d   = ST_FETCH;
          rd_addr_d = nb_addr_w;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ph_d       = 3'd0;
        rd_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      ph_q       <= 3'd0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      l_q        <= '0;
      r_q        <= '0;
      u_q        <= '0;
      wr_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      l_q        <= l_d;
      r_q        <= r_d;
      u_q        <= u_d;
      wr_addr_q  <= wr_addr_d;
      wr_valid_q <= wr_valid_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      done_q     <= done_d;
    end
  end

  assign ext_read_addr       = rd_addr_q;
  assign ext_read_addr_valid = rd_valid_q;
  assign x_write_addr        = wr_addr_q;
  assign y_write_addr        = wr_addr_q;
  assign x_write_valid       = wr_valid_q;
  assign y_write_valid       = wr_valid_q;
  assign x_pixel_out         = gx_q;
  assign y_pixel_out         = gy_q;
  assign gradient_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sift_gradient_image.sv
`default_nettype none
// ============================================================================
// Module     : tb_sift_gradient_image
// Description: Self-checking bench for sift_gradient_image on a reduced
//              16x8 image with a 2-cycle registered-output source BRAM model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_sift_gradient_image;

  localparam int W    = 16;
  localparam int H    = 8;
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);
  localparam int FRAME_CYC = 7 * NPIX;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          start_in = 1'b0;
  logic [AW-1:0] ext_read_addr;
  logic          ext_read_addr_valid;
  logic [7:0]    ext_pixel_in;
  logic [AW-1:0] x_write_addr, y_write_addr;
  logic          x_write_valid, y_write_valid;
  logic [7:0]    x_pixel_out, y_pixel_out;
  logic          gradient_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  sift_gradient_image #(
    .BIT_DEPTH (8),
    .WIDTH     (W),
    .HEIGHT    (H)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .ext_read_addr       (ext_read_addr),
    .ext_read_addr_valid (ext_read_addr_valid),
    .ext_pixel_in        (ext_pixel_in),
    .x_write_addr        (x_write_addr),
    .x_write_valid       (x_write_valid),
    .x_pixel_out         (x_pixel_out),
    .y_write_addr        (y_write_addr),
    .y_write_valid       (y_write_valid),
    .y_pixel_out         (y_pixel_out),
    .start_in            (start_in),
    .gradient_done       (gradient_done)
  );

  // Source BRAM: enable on the address stage, output register always on
  logic [7:0] mem [NPIX];
  logic [7:0] bram_r1 = 8'h00, bram_r2 = 8'h00;
  always @(posedge clk_in) begin
    if (ext_read_addr_valid) bram_r1 <= mem[ext_read_addr];
    bram_r2 <= bram_r1;
  end
  assign ext_pixel_in = bram_r2;

  // Write-port monitor
  int q_addr[$];
  int q_x[$];
  int q_y[$];
  int viol = 0;
  bit prev_v = 1'b0;
  always @(negedge clk_in) begin
    if (x_write_valid) begin
      q_addr.push_back(int'(x_write_addr));
      q_x.push_back(int'(x_pixel_out));
      q_y.push_back(int'(y_pixel_out));
    end
    if (x_write_valid !== y_write_valid) viol++;
    if (x_write_valid && (x_write_addr !== y_write_addr)) viol++;
    if (x_write_valid && prev_v) viol++;
    prev_v = x_write_valid;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pix(int x, int y);
    int cx, cy;
    cx = (x < 0) ? 0 : (x > W - 1) ? W - 1 : x;
    cy = (y < 0) ? 0 : (y > H - 1) ? H - 1 : y;
    return int'(mem[cy * W + cx]);
  endfunction

  // floor((hi - lo) / 2), as an 8-bit two's complement code
  function automatic int half_diff(int hi, int lo);
    int d, g;
    d = hi - lo;
    g = (d >= 0) ? d / 2 : -((1 - d) / 2);
    return g & 8'hFF;
  endfunction

  function automatic int exp_gx(int i);
    return half_diff(pix(i % W + 1, i / W), pix(i % W - 1, i / W));
  endfunction

  function automatic int exp_gy(int i);
    return half_diff(pix(i % W, i / W + 1), pix(i % W, i / W - 1));
  endfunction

  task automatic load_image(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       mem[i] = 8'h80;
        1:       mem[i] = 8'(2 * (i % W));
        2:       mem[i] = 8'(255 - 2 * (i / W));
        3:       mem[i] = ((i % W) < W / 2) ? 8'hFF : ((i / W) < H / 2 ? 8'h00 : 8'hFF);
        default: mem[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {23'd0, ext_read_addr, ext_read_addr_valid, x_write_addr, x_write_valid,
            x_pixel_out, y_write_addr, y_write_valid, y_pixel_out, gradient_done};
  endfunction

  task automatic clear_mon();
    q_addr.delete();
    q_x.delete();
    q_y.delete();
  endtask

  // One full frame: start, time done, then compare every write to the model
  task automatic run_frame(input string tag, input bit mid_start);
    int n;
    int bad;
    clear_mon();
    @(negedge clk_in);
    start_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    start_in = 1'b0;
    check_eq({tag, "_done_clr"}, gradient_done, 1'b0);
    n = 0;
    while (!gradient_done && n < FRAME_CYC + 100) begin
      @(posedge clk_in);
      n++;
      @(negedge clk_in);
      start_in = mid_start && (n == 100 || n == 401);
    end
    start_in = 1'b0;
    check_eq({tag, "_done_cyc"}, n, FRAME_CYC);
    repeat (5) @(negedge clk_in);
    check_eq({tag, "_done_hold"}, {gradient_done, ext_read_addr_valid}, 2'b10);
    check_eq({tag, "_nwr"}, q_addr.size(), NPIX);
    bad = 0;
    for (int i = 0; i < q_addr.size() && i < NPIX; i++) begin
      if (q_addr[i] != i || q_x[i] != exp_gx(i) || q_y[i] != exp_gy(i)) begin
        bad++;
        if (bad <= 4)
          $display("  %s pixel %0d: addr=%0d x=%02h y=%02h model x=%02h y=%02h",
                   tag, i, q_addr[i], q_x[i], q_y[i], exp_gx(i), exp_gy(i));
      end
    end
    check_eq({tag, "_pix_bad"}, bad, 0);
    check_eq({tag, "_viol"}, viol, 0);
  endtask

  // Spot checks of specific gradient codes against hand-derived values
  task automatic spot(input string tag, input int i, input int ex, input int ey);
    check_eq({tag, "_x"}, (i < q_x.size()) ? q_x[i] : -1, ex);
    check_eq({tag, "_y"}, (i < q_y.size()) ? q_y[i] : -1, ey);
  endtask

  initial begin
    int t;
    // Reset state (async, before any clock edge matters)
    #2;
    check_eq("reset_outputs", all_outputs(), 64'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check_eq("idle_outputs", all_outputs(), 64'd0);

    load_image(0);
    run_frame("uniform", 1'b0);
    spot("uni_corner", NPIX - 1, 8'h00, 8'h00);

    load_image(1);
    run_frame("hramp", 1'b0);
    spot("hramp_x0", 0, 8'h01, 8'h00);
    spot("hramp_xmid", 5, 8'h02, 8'h00);
    spot("hramp_xlast", W - 1, 8'h01, 8'h00);

    load_image(2);
    run_frame("vramp", 1'b0);
    spot("vramp_y0", 3, 8'h00, 8'hFF);
    spot("vramp_ymid", 2 * W + 3, 8'h00, 8'hFE);
    spot("vramp_ylast", (H - 1) * W + 3, 8'h00, 8'hFF);

    // Step edges: L=255,R=0 floors to -128; U=0,D=255 gives +127
    load_image(3);
    run_frame("step", 1'b0);
    spot("step_fall", W / 2, 8'h80, 8'h00);
    spot("step_rise", (H / 2 - 1) * W + W / 2, 8'h80, 8'h7F);

    load_image(4);
    run_frame("rand1", 1'b0);
    run_frame("rand1_again", 1'b0);

    load_image(4);
    run_frame("rand2_midstart", 1'b1);

    // Reset mid-frame (row 3), then restart from pixel 0
    clear_mon();
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    t = 0;
    while (q_addr.size() < 3 * W + 2 && t < FRAME_CYC) begin
      @(negedge clk_in);
      t++;
    end
    check_eq("midrst_reach", t < FRAME_CYC, 1'b1);
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check_eq("midrst_outputs", all_outputs(), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    clear_mon();
    repeat (60) @(negedge clk_in);
    check_eq("midrst_nowr", q_addr.size(), 0);
    check_eq("midrst_idle", {gradient_done, ext_read_addr_valid}, 2'b00);
    run_frame("after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #(10 * 20 * FRAME_CYC);
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
